// File: rtl/mult_div_unit.sv
// +----------------------------------------------------------------------------+
// | mult_div_unit: iterative radix-2 multiply / restoring divide, HI/LO out.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FINISH    = 2'd2,
    FINISH_DZ = 2'd3
  } state_t;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] quo;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   rem;

  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH+1:0]   div_ext;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_signed = ~op[0];
  assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  // Next iteration of both datapaths; the FINISH result is taken from the last step.
  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    div_ext  = {rem, quo[WIDTH-1]};
    div_diff = div_ext - {2'b00, opb};
    div_neg  = div_diff[WIDTH+1];
    rem_step = div_neg ? div_ext[WIDTH:0] : div_diff[WIDTH:0];
    quo_step = {quo[WIDTH-2:0], ~div_neg};
    prod_fix = (neg_a ^ neg_b) ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
    quo_fix  = (neg_a ^ neg_b) ? -quo_step : quo_step;
    rem_fix  = neg_a ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      opb      <= '0;
      quo      <= '0;
      acc      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            is_div   <= op[1];
            neg_a    <= op_signed & a[WIDTH-1];
            neg_b    <= op_signed & b[WIDTH-1];
            count    <= '0;
            busy     <= 1'b1;
            if (op[1] && (b == '0)) begin
              state    <= FINISH_DZ;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              opb   <= mag_b;
              acc   <= {{(WIDTH+1){1'b0}}, mag_a};
              quo   <= mag_a;
              rem   <= '0;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          acc   <= acc_step;
          rem   <= rem_step;
          quo   <= quo_step;
          if (count == LAST) begin
            state <= FINISH;
            done  <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        FINISH, FINISH_DZ: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
`default_nettype none

module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp32_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
  } exp8_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  exp32_t q32[$];
  exp8_t  q8[$];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  // Scoreboard: every done pops one expectation; done must never last two cycles.
  logic prev_done32 = 1'b0;
  always @(negedge clk) begin : mon32
    exp32_t e;
    if (done32 === 1'b1) begin
      checks++;
      if (prev_done32) begin
        errors++;
        $display("FAIL done32_double: done high two consecutive cycles");
      end
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL done32_unexpected: hi=%h lo=%h dz=%b with nothing pending", hi32, lo32, dz32);
      end else begin
        e = q32.pop_front();
        if ({hi32, lo32, dz32} !== {e.hi, e.lo, e.dz}) begin
          errors++;
          $display("FAIL result32: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                   hi32, lo32, dz32, e.hi, e.lo, e.dz);
        end
      end
    end
    prev_done32 = (done32 === 1'b1);
  end

  always @(negedge clk) begin : mon8
    exp8_t e;
    if (done8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: hi=%h lo=%h", hi8, lo8);
      end else begin
        e = q8.pop_front();
        if ({hi8, lo8, dz8} !== {e.hi, e.lo, 1'b0}) begin
          errors++;
          $display("FAIL result8: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=0",
                   hi8, lo8, dz8, e.hi, e.lo);
        end
      end
    end
  end

  task automatic do32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input logic edz,
                      input int lat);
    int cyc;
    @(posedge clk); #1;
    checks++;
    if (busy32 !== 1'b0) begin
      errors++;
      $display("FAIL busy32_idle_before_start: got %b required 0", busy32);
    end
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    q32.push_back('{eh, el, edz});
    @(posedge clk); #1;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
    cyc = 1;
    checks++;
    if (busy32 !== 1'b1 || dz32 !== edz) begin
      errors++;
      $display("FAIL cycle1_32: busy=%b div_zero=%b required busy=1 div_zero=%b", busy32, dz32, edz);
    end
    while (done32 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done32 !== 1'b1 || cyc != lat) begin
      errors++;
      $display("FAIL latency32: done after %0d cycles required %0d", cyc, lat);
      if (done32 !== 1'b1) q32.delete();
    end
    @(posedge clk); #1;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL after_done32: busy=%b done=%b required 0 0", busy32, done32);
    end
  endtask

  task automatic do8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] eh, input logic [7:0] el, input int lat);
    int cyc;
    @(posedge clk); #1;
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back('{eh, el});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done8 !== 1'b1 || cyc != lat) begin
      errors++;
      $display("FAIL latency8: done after %0d cycles required %0d", cyc, lat);
      if (done8 !== 1'b1) q8.delete();
    end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL after_done8: busy=%b required 0", busy8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy32, done32, dz32, hi32, lo32} !== '0 || {busy8, done8, dz8, hi8, lo8} !== '0) begin
      errors++;
      $display("FAIL reset_state: dut32 b/d/z=%b%b%b hi=%h lo=%h dut8 b/d/z=%b%b%b hi=%h lo=%h required all 0",
               busy32, done32, dz32, hi32, lo32, busy8, done8, dz8, hi8, lo8);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    do32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
  endtask

  task automatic test_signed();
    do32(OP_MULT, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33);
    do32(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    do32(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
    do32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
  endtask

  task automatic test_div_zero();
    do32(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    do32(OP_DIV, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dz32 !== 1'b1 || hi32 !== 32'd2 || lo32 !== 32'd14) begin
      errors++;
      $display("FAIL div_zero_hold: dz=%b hi=%h lo=%h required 1 2 14", dz32, hi32, lo32);
    end
    do32(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int extra;
    @(posedge clk); #1;
    op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    q32.push_back('{32'd2, 32'd14, 1'b0});
    @(posedge clk); #1;
    op32 = OP_MULTU; a32 = 32'd9; b32 = 32'd9;
    cyc = 1;
    while (done32 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL busy_start_ignored: done after %0d cycles required 33", cyc);
    end
    @(posedge clk); #1;
    start32 = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || q32.size() != 0) begin
      errors++;
      $display("FAIL done_cycle_start_ignored: %0d extra done pulses required 0", extra);
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start32 = (c == 3);
      if (c == 3) begin op32 = OP_MULT; a32 = 32'd55; b32 = 32'd66; end
      if (done32 === 1'b1) seen++;
      if (c == 10) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start32 = 1'b0;
    checks++;
    if ({busy32, done32, dz32, hi32, lo32} !== '0 || seen != 0) begin
      errors++;
      $display("FAIL abort_reset: b/d/z=%b%b%b hi=%h lo=%h done_seen=%0d required all 0",
               busy32, done32, dz32, hi32, lo32, seen);
    end
    do32(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
  endtask

  task automatic test_random();
    logic [31:0] x, y, eh, el;
    logic [63:0] p;
    longint sa, sb;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] o;
      o = 2'(i % 4);
      x = $urandom;
      y = $urandom;
      if (o[1] && y == 32'd0) y = 32'd1;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      case (o)
        OP_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
        OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
        OP_DIV:   begin el = 32'(sa / sb); eh = 32'(sa % sb); end
        default:  begin el = x / y; eh = x % y; end
      endcase
      do32(o, x, y, eh, el, 1'b0, 33);
    end
  endtask

  task automatic test_width8();
    do8(OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 9);
    do8(OP_DIVU, 8'd100, 8'd7, 8'd2, 8'd14, 9);
    do8(OP_MULT, 8'h80, 8'hFF, 8'h00, 8'h80, 9);
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_random();
    test_width8();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
